alu_cluster: RTL



---
 rtl/alu_cluster_pkg.sv | 34 +++
 rtl/alu_lane.sv | 153 +++++++++++++++
 rtl/alu_cluster.sv | 50 +++++
 3 files changed

// File: rtl/alu_cluster_pkg.sv
// Shared definitions for the ALU cluster: opcode encoding, default widths
// and the per-lane result record.
package alu_cluster_pkg;

  localparam int ALU_OP_W     = 4;
  localparam int CL_DATA_W    = 32;
  localparam int CL_ROB_IDX_W = 6;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_NOR   = 4'd5,
    ALU_SLL   = 4'd6,
    ALU_SRL   = 4'd7,
    ALU_SRA   = 4'd8,
    ALU_SLT   = 4'd9,
    ALU_SLTU  = 4'd10,
    ALU_PASS1 = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic [CL_DATA_W-1:0]    data;
    logic [CL_ROB_IDX_W-1:0] rob_idx;
  } lane_result_t;

  // One extra pointer bit separates a full FIFO from an empty one.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/alu_lane.sv
// One ALU lane: compute at entry, fixed-depth shift pipeline, in-order
// commit FIFO, and credit-based issue ready that never stalls the pipe.
module alu_lane
  import alu_cluster_pkg::*;
#(
  parameter int DATA_W      = CL_DATA_W,
  parameter int ROB_IDX_W   = CL_ROB_IDX_W,
  parameter int PIPE_STAGES = 2,
  parameter int CMT_DEPTH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic                 exe_valid_i,
  output logic                 exe_ready_o,
  input  logic [ALU_OP_W-1:0]  exe_op_i,
  input  logic [DATA_W-1:0]    exe_src0_i,
  input  logic [DATA_W-1:0]    exe_src1_i,
  input  logic [ROB_IDX_W-1:0] exe_rob_idx_i,
  output logic                 cmt_valid_o,
  input  logic                 cmt_ready_i,
  output logic [DATA_W-1:0]    cmt_data_o,
  output logic [ROB_IDX_W-1:0] cmt_rob_idx_o
);

  localparam int SH_W  = $clog2(DATA_W);
  localparam int AW    = $clog2(CMT_DEPTH);
  localparam int PTR_W = ptr_w(CMT_DEPTH);
  localparam int CNT_W = PTR_W + 2;

  typedef struct packed {
    logic [DATA_W-1:0]    data;
    logic [ROB_IDX_W-1:0] rob_idx;
  } entry_t;

  logic                   accept;
  logic [SH_W-1:0]        shamt;
  logic [DATA_W-1:0]      alu_result;
  logic [PIPE_STAGES-1:0] stg_valid;
  entry_t                 stg_ent [PIPE_STAGES];

  entry_t                 fifo_mem [CMT_DEPTH];
  entry_t                 head;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]       occ;
  logic [CNT_W-1:0]       inflight;
  logic [CNT_W-1:0]       credit_used;
  logic                   push, pop, fifo_empty, fifo_full;

  assign shamt = exe_src1_i[SH_W-1:0];

  always_comb begin
    alu_result = '0;
    case (alu_op_e'(exe_op_i))
      ALU_ADD:   alu_result = exe_src0_i + exe_src1_i;
      ALU_SUB:   alu_result = exe_src0_i - exe_src1_i;
      ALU_AND:   alu_result = exe_src0_i & exe_src1_i;
      ALU_OR:    alu_result = exe_src0_i | exe_src1_i;
      ALU_XOR:   alu_result = exe_src0_i ^ exe_src1_i;
      ALU_NOR:   alu_result = ~(exe_src0_i | exe_src1_i);
      ALU_SLL:   alu_result = exe_src0_i << shamt;
      ALU_SRL:   alu_result = exe_src0_i >> shamt;
      ALU_SRA:   alu_result = $unsigned($signed(exe_src0_i) >>> shamt);
      ALU_SLT:   alu_result = DATA_W'($signed(exe_src0_i) < $signed(exe_src1_i));
      ALU_SLTU:  alu_result = DATA_W'(exe_src0_i < exe_src1_i);
      ALU_PASS1: alu_result = exe_src1_i;
      default:   alu_result = '0;
    endcase
  end

  // A flush cycle drops the offered op even when credit was available.
  assign accept = exe_valid_i && exe_ready_o && !flush_i;

  for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
    logic   valid_q, valid_d;
    entry_t ent_q, ent_d;

    if (gi == 0) begin : g_first
      always_comb begin
        valid_d = accept;
        ent_d   = '{data: alu_result, rob_idx: exe_rob_idx_i};
      end
    end else begin : g_next
      always_comb begin
        valid_d = stg_valid[gi-1] && !flush_i;
        ent_d   = stg_ent[gi-1];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_q <= 1'b0;
      end else begin
        valid_q <= valid_d;
      end
      ent_q <= ent_d;
    end

    assign stg_valid[gi] = valid_q;
    assign stg_ent[gi]   = ent_q;
  end

  always_comb begin
    push        = stg_valid[PIPE_STAGES-1];
    fifo_empty  = (wr_ptr_q == rd_ptr_q);
    fifo_full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop         = !fifo_empty && cmt_ready_i;
    occ         = wr_ptr_q - rd_ptr_q;
    inflight    = '0;
    for (int i = 0; i < PIPE_STAGES; i++) begin
      inflight = inflight + CNT_W'(stg_valid[i]);
    end
    credit_used = inflight + CNT_W'(occ);
    wr_ptr_d    = wr_ptr_q + PTR_W'(push);
    rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !fifo_full) begin
      fifo_mem[wr_ptr_q[AW-1:0]] <= stg_ent[PIPE_STAGES-1];
    end
  end

  // Credit accounting must make an overflowing push impossible.
  always_ff @(posedge clk) begin
    if (!rst && !flush_i) begin
      assert (!(push && fifo_full));
    end
  end

  assign head          = fifo_mem[rd_ptr_q[AW-1:0]];
  assign cmt_valid_o   = !fifo_empty;
  assign cmt_data_o    = fifo_empty ? '0 : head.data;
  assign cmt_rob_idx_o = fifo_empty ? '0 : head.rob_idx;
  assign exe_ready_o   = credit_used < CNT_W'(CMT_DEPTH);

endmodule

// File: rtl/alu_cluster.sv
// NUM_LANES independent ALU lanes behind flat, lane-sliced issue and
// commit buses; lanes share only clock, reset and flush.
module alu_cluster
  import alu_cluster_pkg::*;
#(
  parameter int NUM_LANES   = 2,
  parameter int DATA_W      = CL_DATA_W,
  parameter int ROB_IDX_W   = CL_ROB_IDX_W,
  parameter int PIPE_STAGES = 2,
  parameter int CMT_DEPTH   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           flush_i,
  input  logic [NUM_LANES-1:0]           exe_valid_i,
  output logic [NUM_LANES-1:0]           exe_ready_o,
  input  logic [ALU_OP_W*NUM_LANES-1:0]  exe_op_i,
  input  logic [DATA_W*NUM_LANES-1:0]    exe_src0_i,
  input  logic [DATA_W*NUM_LANES-1:0]    exe_src1_i,
  input  logic [ROB_IDX_W*NUM_LANES-1:0] exe_rob_idx_i,
  output logic [NUM_LANES-1:0]           cmt_valid_o,
  input  logic [NUM_LANES-1:0]           cmt_ready_i,
  output logic [DATA_W*NUM_LANES-1:0]    cmt_data_o,
  output logic [ROB_IDX_W*NUM_LANES-1:0] cmt_rob_idx_o
);

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    alu_lane #(
      .DATA_W     (DATA_W),
      .ROB_IDX_W  (ROB_IDX_W),
      .PIPE_STAGES(PIPE_STAGES),
      .CMT_DEPTH  (CMT_DEPTH)
    ) u_lane (
      .clk          (clk),
      .rst          (rst),
      .flush_i      (flush_i),
      .exe_valid_i  (exe_valid_i[gi]),
      .exe_ready_o  (exe_ready_o[gi]),
      .exe_op_i     (exe_op_i[gi*ALU_OP_W +: ALU_OP_W]),
      .exe_src0_i   (exe_src0_i[gi*DATA_W +: DATA_W]),
      .exe_src1_i   (exe_src1_i[gi*DATA_W +: DATA_W]),
      .exe_rob_idx_i(exe_rob_idx_i[gi*ROB_IDX_W +: ROB_IDX_W]),
      .cmt_valid_o  (cmt_valid_o[gi]),
      .cmt_ready_i  (cmt_ready_i[gi]),
      .cmt_data_o   (cmt_data_o[gi*DATA_W +: DATA_W]),
      .cmt_rob_idx_o(cmt_rob_idx_o[gi*ROB_IDX_W +: ROB_IDX_W])
    );
  end

endmodule
